// File: rtl/data_sram_responder.sv
// CPU data-side SRAM responder: block-RAM store plus a config-register window (LED, SWITCH, TIMER, SCRATCH).
// Optional macro CONFREG_TIMER_EN enables the free-running TIMER register; otherwise offset 0x0008 reads 0.
module data_sram_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] CONF_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  sw,
  output logic [15:0] led
);

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SW      = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_SCRATCH = 16'h000C;

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] nw,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? nw[8*i +: 8] : cur[8*i +: 8];
    return res;
  endfunction

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              conf_sel;
  logic [15:0]       conf_off;
  logic              req;
  logic              conf_wr;
  logic [7:0]        sw_meta, sw_sync;
  logic [15:0]       led_q;
  logic [31:0]       scratch_q;
  logic [31:0]       timer_q;
  logic [31:0]       conf_rd;

  assign ram_idx  = addr[RAM_AW+1:2];
  assign conf_sel = (addr[31:16] == CONF_BASE);
  assign conf_off = addr[15:0];
  // A request on a reset edge is dropped entirely.
  assign req      = en & resetn;
  assign conf_wr  = req & conf_sel & (|wen);
  assign led      = led_q;

  always_comb begin
    conf_rd = '0;
    case (conf_off)
      OFF_LED:     conf_rd = {16'h0000, led_q};
      OFF_SW:      conf_rd = {24'h000000, sw_sync};
      OFF_TIMER:   conf_rd = timer_q;
      OFF_SCRATCH: conf_rd = scratch_q;
      default:     conf_rd = '0;
    endcase
  end

  // RAM array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (req && !conf_sel) begin
      for (int i = 0; i < 4; i++)
        if (wen[i]) ram[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read-first capture: rdata sees the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (!resetn)
      rdata <= '0;
    else if (en)
      rdata <= conf_sel ? conf_rd : ram[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      led_q     <= '0;
      scratch_q <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (conf_wr && conf_off == OFF_LED) begin
        if (wen[0]) led_q[7:0]  <= wdata[7:0];
        if (wen[1]) led_q[15:8] <= wdata[15:8];
      end
      if (conf_wr && conf_off == OFF_SCRATCH)
        scratch_q <= merge_lanes(scratch_q, wdata, wen);
    end
  end

`ifdef CONFREG_TIMER_EN
  // A write to the timer replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (!resetn)
      timer_q <= '0;
    else if (conf_wr && conf_off == OFF_TIMER)
      timer_q <= merge_lanes(timer_q, wdata, wen);
    else
      timer_q <= timer_q + 32'd1;
  end
`else
  assign timer_q = '0;
`endif

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder for the CPU data-side SRAM port: the memory/peripheral end of the `data_sram_*` interface that the CPU top drives. It serves word accesses with byte-lane write enables and returns read data exactly one cycle after the request. A block-RAM store covers the general address space. A small configuration-register window holds LED, switch, scratch and free-running timer registers, and is decoded by the upper address bits. It sits outside the CPU, wired directly to `data_sram_en/wen/addr/wdata/rdata`.

## Interface
- `RAM_AW`, 14: RAM word-address width (2^14 words = 64 KiB); RAM is indexed by `addr[RAM_AW+1:2]`.
- `CONF_BASE`, 16'hBFAF: value of `addr[31:16]` that selects the config-register window.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `en`  in  1  request valid this cycle.
- `wen`  in  4  byte-lane write enables; bit i writes `wdata[8i+7:8i]`; 0 means a read.
- `addr`  in  32  byte address; `addr[1:0]` is ignored (word access).
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `sw`  in  8  asynchronous switch inputs.
- `led`  out  16  LED register output.

## Operation
- Decode: `conf_sel = (addr[31:16] == CONF_BASE)`. Otherwise the access targets RAM; upper bits above `RAM_AW+1` alias.
- Config offsets use `addr[15:0]`:
  - 0x0000 LED: RW, bits [15:0]; reads are zero-extended.
  - 0x0004 SWITCH: RO, synchronized `sw`, zero-extended; writes are ignored.
  - 0x0008 TIMER: RW, 32-bit.
  - 0x000C SCRATCH: RW, 32-bit.
  - Any other offset reads 0; writes to it are ignored.
- Writes: when `en=1`, each enabled byte lane of the target is updated at the edge. Disabled lanes keep their value.
- Reads: when `en=1`, the target word is captured into `rdata` at the edge. This happens for every request, write or read; a write returns the pre-write word (read-first).
- When `en=0`, `rdata` holds its previous value, and RAM and registers are not written.
- Switch path: two-flop synchronizer. SWITCH reads the value of `sw` sampled two edges earlier.
- TIMER:
  - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - A write to TIMER takes precedence for the enabled lanes: next value = merge(current, `wdata`, `wen`), with no increment that cycle.
  - A TIMER read returns the value before that edge's update.

## Timing
- Read latency is exactly 1 cycle: a request at edge N gives `rdata` valid after edge N and stable until the next `en=1` edge.
- Back-to-back requests are supported every cycle with no bubbles and no stall output.
- Read after write to the same address: a request at N+1 returns the data written at N.
- Reset, on an edge with `resetn=0`:
  - `rdata`=0, `led`=0, TIMER=0, SCRATCH=0, synchronizer flops=0.
  - RAM contents are not reset.
  - A request presented on a reset edge is discarded: no write, `rdata`=0.
- First edge after release: TIMER becomes 1.

## Configuration
- `CONFREG_TIMER_EN` defined: TIMER is implemented as described above.
- `CONFREG_TIMER_EN` undefined: there is no counter logic; offset 0x0008 reads 0 and writes are ignored. All other behaviour is unchanged.

## Test plan
- RAM write/read: write 0x12345678 to 0x00000010 with `wen`=4'hF, then read 0x00000010 next cycle → `rdata`=0x12345678 one cycle after the read request.
- Byte lanes: starting from 0x12345678, write `wdata`=0xAABBCCDD with `wen`=4'b0101, then read → 0x12BB56DD.
- Read-first: write 0xCAFEF00D to a word holding 0x11111111 → `rdata` after that edge is 0x11111111; a following read returns 0xCAFEF00D.
- Config window:
  - Write 0x0001ABCD to 0xBFAF0000 → `led`=0xABCD and a readback returns 0x0000ABCD.
  - Hold `sw`=0x5A for 3+ cycles, then read 0xBFAF0004 → 0x0000005A.
  - Read 0xBFAF0020 → 0.
- Timer (with `CONFREG_TIMER_EN`):
  - Write 0xFFFFFFFE to 0xBFAF0008 → reads on the next two cycles return 0xFFFFFFFE and 0xFFFFFFFF; the third read returns 0.
  - Without the macro, a TIMER read returns 0.
- Reset mid-operation: assert `resetn=0` on the same edge as a write to SCRATCH → SCRATCH=0, `rdata`=0, `led`=0. After release, a SCRATCH read returns 0.
